// File: rtl/sample_packer.sv
// sample_packer: packs narrow valid/ready samples into wide words with an output holding register and flush
module sample_packer #(
  parameter int IN_W = 2,
  parameter int OUT_W = 16,
  parameter bit MSB_FIRST = 1,
  localparam int N = OUT_W / IN_W,
  localparam int CW = $clog2(N + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [CW-1:0]   out_samples,
  input  logic            out_ready
);
  localparam int KW = N > 1 ? $clog2(N) : 1;
  if (OUT_W % IN_W != 0) begin : g_bad_width
    $error("sample_packer: OUT_W must be a multiple of IN_W");
  end
  logic [KW-1:0] cnt, cnt_nxt, sidx;
  logic [OUT_W-1:0] acc, merged, acc_nxt, data_nxt;
  logic [CW-1:0] eff, samples_nxt;
  logic flush_pend, pend_nxt, valid_nxt, out_free, accept, last, flush_go, load;
  // handshake, slot merge and next-state: a word loads on completion or on an effective flush with a free output
  always_comb begin
    out_free = !out_valid || out_ready;
    in_ready = !flush_pend && (cnt != KW'(N - 1) || out_free);
    accept = in_valid && in_ready;
    last = accept && cnt == KW'(N - 1);
    sidx = MSB_FIRST ? KW'(N - 1) - cnt : cnt;
    merged = acc;
    for (int j = 0; j < N; j++)
      if (accept && sidx == KW'(j)) merged[j*IN_W +: IN_W] = in_data;
    eff = CW'(cnt) + CW'(accept);
    flush_go = (flush || flush_pend) && !last && eff != '0;
    load = last || (flush_go && out_free);
    cnt_nxt = load ? '0 : cnt + KW'(accept);
    acc_nxt = load ? '0 : merged;
    pend_nxt = flush_go && !out_free;
    valid_nxt = load || (out_valid && !out_ready);
    data_nxt = load ? merged : out_data;
    samples_nxt = load ? eff : out_samples;
  end
  // state registers; reset discards any partial or held word
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      flush_pend <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_samples <= '0;
    end else begin
      cnt <= cnt_nxt;
      acc <= acc_nxt;
      flush_pend <= pend_nxt;
      out_valid <= valid_nxt;
      out_data <= data_nxt;
      out_samples <= samples_nxt;
    end
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: scoreboard bench for sample_packer with MSB-first and LSB-first instances
module tb_sample_packer;
  typedef struct {
    logic [15:0] dm;
    logic [15:0] dl;
    logic [3:0]  ns;
  } exp_t;
  logic clock = 0, reset = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [1:0] in_data = 0;
  logic in_ready0, in_ready1, out_valid0, out_valid1;
  logic [15:0] out_data0, out_data1;
  logic [3:0] out_samples0, out_samples1;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, k = 0;
  logic [15:0] wm = 0, wl = 0;
  bit acc_seen;

  always #5 clock = ~clock;

  sample_packer #(.IN_W(2), .OUT_W(16), .MSB_FIRST(1)) u_msb (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .flush(flush), .out_valid(out_valid0), .out_data(out_data0), .out_samples(out_samples0),
    .out_ready(out_ready));
  sample_packer #(.IN_W(2), .OUT_W(16), .MSB_FIRST(0)) u_lsb (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .flush(flush), .out_valid(out_valid1), .out_data(out_data1), .out_samples(out_samples1),
    .out_ready(out_ready));

  task automatic step(input logic v, input logic [1:0] d, input logic f, input logic r);
    exp_t e;
    @(negedge clock);
    in_valid = v; in_data = d; flush = f; out_ready = r;
    #1;
    if (out_valid0 && r) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word got=%h n=%0d", out_data0, out_samples0);
      end else begin
        e = sb.pop_front();
        if ({out_data0, out_samples0} !== {e.dm, e.ns}) begin
          n_bad++;
          $display("FAIL msb_word got=%h/%0d exp=%h/%0d", out_data0, out_samples0, e.dm, e.ns);
        end
        n_cmp++;
        if ({out_valid1, out_data1, out_samples1} !== {1'b1, e.dl, e.ns}) begin
          n_bad++;
          $display("FAIL lsb_word got=%b/%h/%0d exp=1/%h/%0d", out_valid1, out_data1, out_samples1, e.dl, e.ns);
        end
      end
    end
    if (v) begin
      n_cmp++;
      if (in_ready1 !== in_ready0) begin
        n_bad++;
        $display("FAIL ready_agree lsb=%b msb=%b", in_ready1, in_ready0);
      end
    end
    acc_seen = v && in_ready0;
    if (acc_seen) begin
      wm[15-2*k -: 2] = d;
      wl[2*k +: 2] = d;
      k++;
    end
    if (k == 8 || (f && k > 0)) begin
      sb.push_back('{wm, wl, 4'(k)});
      wm = 0; wl = 0; k = 0;
    end
  endtask

  task automatic pulse_reset;
    @(posedge clock);
    #3;
    in_valid = 0; flush = 0;
    reset = 1;
    #1;
    n_cmp++;
    if ({out_valid0, out_data0, out_samples0, in_ready0} !== {1'b0, 16'h0, 4'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL async_reset got v=%b d=%h n=%0d rdy=%b exp v=0 d=0000 n=0 rdy=1",
               out_valid0, out_data0, out_samples0, in_ready0);
    end
    sb.delete(); wm = 0; wl = 0; k = 0;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 10; i++) step(1, 2'(i), 0, 0);
    pulse_reset();
    step(0, 0, 0, 1);
    n_cmp++;
    if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_idle got=%b exp=0", out_valid0); end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 8; i++) step(1, 2'(i), 0, 1);
    n_cmp++;
    if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL stream_early got=%b exp=0", out_valid0); end
    step(0, 0, 0, 1);
    n_cmp++;
    if ({out_valid0, out_data0, out_data1} !== {1'b1, 16'h1B1B, 16'hE4E4}) begin
      n_bad++;
      $display("FAIL stream_word got=%b/%h/%h exp=1/1b1b/e4e4", out_valid0, out_data0, out_data1);
    end
    step(0, 0, 0, 1);
    n_cmp++;
    if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL stream_drain got=%b exp=0", out_valid0); end
  endtask

  task automatic test_back_to_back;
    int i = 0;
    for (int c = 0; c < 16; c++) begin
      step(1, 2'(i ^ (i >> 3)), 0, 0);
      if (acc_seen) i++;
    end
    n_cmp++;
    if (i != 15 || in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || out_data0 !== 16'h1B1B) begin
      n_bad++;
      $display("FAIL b2b_stall got acc=%0d rdy=%b v=%b d=%h exp acc=15 rdy=0 v=1 d=1b1b",
               i, in_ready0, out_valid0, out_data0);
    end
    step(1, 2'(i ^ (i >> 3)), 0, 1);
    if (acc_seen) i++;
    step(0, 0, 0, 0);
    n_cmp++;
    if ({i[4:0], out_valid0, in_ready0, out_data0} !== {5'd16, 1'b1, 1'b1, 16'h4E4E}) begin
      n_bad++;
      $display("FAIL b2b_load got acc=%0d v=%b rdy=%b d=%h exp acc=16 v=1 rdy=1 d=4e4e",
               i, out_valid0, in_ready0, out_data0);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    n_cmp++;
    if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid0); end
  endtask

  task automatic test_flush;
    step(1, 1, 0, 1); step(1, 2, 0, 1); step(1, 3, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    n_cmp++;
    if ({out_valid0, out_data0, out_samples0} !== {1'b1, 16'h6C00, 4'd3}) begin
      n_bad++;
      $display("FAIL flush_partial got=%b/%h/%0d exp=1/6c00/3", out_valid0, out_data0, out_samples0);
    end
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    n_cmp++;
    if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL flush_empty got=%b exp=0", out_valid0); end
    step(1, 2, 1, 1);
    step(0, 0, 0, 1);
    n_cmp++;
    if ({out_data0, out_samples0} !== {16'h8000, 4'd1}) begin
      n_bad++;
      $display("FAIL flush_with_accept got=%h/%0d exp=8000/1", out_data0, out_samples0);
    end
    for (int i = 0; i < 7; i++) step(1, 2'(i), 0, 1);
    step(1, 3, 1, 1);
    step(0, 0, 0, 1);
    n_cmp++;
    if (out_samples0 !== 4'd8) begin n_bad++; $display("FAIL flush_full got=%0d exp=8", out_samples0); end
    step(0, 0, 0, 1);
    n_cmp++;
    if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL flush_full_extra got=%b exp=0", out_valid0); end
  endtask

  task automatic test_flush_pend;
    for (int i = 0; i < 8; i++) step(1, 2'(i), 0, 0);
    step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0);
      n_cmp++;
      if (in_ready0 !== 1'b0) begin n_bad++; $display("FAIL pend_ready got=%b exp=0", in_ready0); end
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    n_cmp++;
    if ({in_ready0, out_valid0, out_samples0, out_data0} !== {1'b1, 1'b1, 4'd3, 16'h6C00}) begin
      n_bad++;
      $display("FAIL pend_load got rdy=%b v=%b n=%0d d=%h exp rdy=1 v=1 n=3 d=6c00",
               in_ready0, out_valid0, out_samples0, out_data0);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    n_cmp++;
    if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL pend_drain got=%b exp=0", out_valid0); end
  endtask

  task automatic test_reset_midword;
    for (int i = 0; i < 5; i++) step(1, 3, 0, 1);
    pulse_reset();
    for (int i = 0; i < 8; i++) step(1, 2'(i), 0, 1);
    step(0, 0, 0, 1);
    n_cmp++;
    if ({out_data0, out_samples0} !== {16'h1B1B, 4'd8}) begin
      n_bad++;
      $display("FAIL fresh_word got=%h/%0d exp=1b1b/8", out_data0, out_samples0);
    end
    step(0, 0, 0, 1);
    n_cmp++;
    if (out_valid0 !== 1'b0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL fresh_only got v=%b pending=%0d exp v=0 pending=0", out_valid0, sb.size());
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush();
    test_flush_pend();
    test_reset_midword();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
